// File: rtl/data_memory_if.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_if
// Purpose  : Load/store bus between the datapath and the data memory.
// Revision : 1.0  initial release
// ============================================================================
interface data_memory_if;
    logic        WE;
    logic [31:0] A;
    logic [31:0] WD;
    logic [31:0] RD;

    modport master (output WE, output A, output WD, input  RD);
    modport slave  (input  WE, input  A, input  WD, output RD);
endinterface
`default_nettype wire

// File: rtl/data_memory.sv
`default_nettype none
// ============================================================================
// Module   : data_memory
// Purpose  : Word-organised data memory, combinational read, clocked write,
//            asynchronous reset to a fixed two-word preload image.
// Revision : 1.0  initial release
// ============================================================================
module data_memory #(
    parameter int          DEPTH      = 256,
    parameter int          INIT_ADDR0 = 1000,
    parameter logic [31:0] INIT_DATA0 = 32'h21212121,
    parameter int          INIT_ADDR1 = 1004,
    parameter logic [31:0] INIT_DATA1 = 32'h23232323
) (
    input  wire logic        clk,
    input  wire logic        rst,
    data_memory_if.slave     bus
);

    localparam int          c_IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] c_DEPTH_W = 32'(DEPTH);
    localparam int          c_IDX0    = INIT_ADDR0 / 4;
    localparam int          c_IDX1    = INIT_ADDR1 / 4;

    logic [31:0]      r_mem [DEPTH];
    logic [31:0]      w_word_addr;
    logic             w_in_range;
    logic [c_IW-1:0]  w_index;

    // Byte lanes are not supported, so the low two address bits drop out here.
    assign w_word_addr = bus.A >> 2;
    assign w_in_range  = (w_word_addr < c_DEPTH_W);
    assign w_index     = w_word_addr[c_IW-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i == c_IDX0)
                    r_mem[i] <= INIT_DATA0;
                else if (i == c_IDX1)
                    r_mem[i] <= INIT_DATA1;
                else
                    r_mem[i] <= 32'h0;
            end
        end else if (bus.WE && w_in_range) begin
            r_mem[w_index] <= bus.WD;
        end
    end

    // No write-data bypass: a same-word write only shows after the edge.
    assign bus.RD = w_in_range ? r_mem[w_index] : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_data_memory.sv
`default_nettype none
// Randomised scoreboard bench for data_memory against a word-indexed
// associative-array model of the memory image.
module tb_data_memory;

    localparam int DEPTH = 256;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] exp;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    data_memory_if bus ();

    data_memory dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    exp_t        sb_q[$];
    logic [31:0] model [int unsigned];
    int          checks   = 0;
    int          failures = 0;

    function automatic void model_reset();
        model.delete();
        model[1000 / 4] = 32'h21212121;
        model[1004 / 4] = 32'h23232323;
    endfunction

    function automatic logic [31:0] model_read(logic [31:0] addr);
        int unsigned idx;
        idx = addr >> 2;
        if (idx >= DEPTH) return 32'h0;
        if (model.exists(idx)) return model[idx];
        return 32'h0;
    endfunction

    function automatic void model_write(logic [31:0] addr, logic [31:0] data);
        int unsigned idx;
        idx = addr >> 2;
        if (idx < DEPTH) model[idx] = data;
    endfunction

    // Monitor: a sample is due on every falling edge that has a pending entry.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            checks++;
            if (bus.RD !== e.exp) begin
                failures++;
                $display("FAIL %s: A=%h RD=%h expected=%h", e.name, e.addr, bus.RD, e.exp);
            end
        end
    end

    // All tasks are entered one time unit after a rising edge.
    task automatic expect_rd(input logic [31:0] addr, input string name);
        exp_t e;
        bus.A  = addr;
        e.addr = addr;
        e.exp  = model_read(addr);
        e.name = name;
        sb_q.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input string name);
        exp_t e;
        bus.A  = addr;
        bus.WD = data;
        bus.WE = 1'b1;
        e.addr = addr;
        e.exp  = model_read(addr);
        e.name = {name, "_pre_edge"};
        sb_q.push_back(e);
        @(posedge clk);
        model_write(addr, data);
        #1;
        bus.WE = 1'b0;
        expect_rd(addr, name);
    endtask

    task automatic idle_edge(input logic [31:0] addr, input logic [31:0] data);
        bus.A  = addr;
        bus.WD = data;
        bus.WE = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time=%0t limit=200000", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.WE = 1'b0;
        bus.A  = 32'd1000;
        bus.WD = 32'h0;
        model_reset();

        rst = 1'b1;
        #10;
        rst = 1'b0;
        @(posedge clk); #1;

        expect_rd(32'd1000, "preload0");
        expect_rd(32'd1004, "preload1");
        expect_rd(32'd1020, "uninit_word");
        expect_rd(32'd0,    "word0_reset");

        do_write(32'd1010, 32'hA5A5A5A5, "write_unaligned");
        expect_rd(32'd1008, "aligned_alias");
        expect_rd(32'd1011, "alias_low_bits");

        do_write(32'd1000, 32'hDEADBEEF, "overwrite_preload");
        expect_rd(32'd1004, "preload1_kept");

        idle_edge(32'd1012, 32'hFFFFFFFF);
        expect_rd(32'd1012, "we_low_no_write");

        do_write(32'd4096, 32'h12345678, "oor_write_4096");
        expect_rd(32'd0, "oor_no_wrap_word0");
        do_write(32'd5096, 32'h0BADF00D, "oor_write_5096");
        expect_rd(32'd1000, "oor_no_wrap_1000");
        expect_rd(32'hFFFF_FFFC, "oor_read_top");

        do_write(32'd1020, 32'h5A5A5A5A, "write_1020");
        do_write(32'd0,    32'h00000001, "write_word0");
        do_write(32'd1020, 32'hC3C3C3C3, "rewrite_1020");

        // Random mix of writes, idle cycles and reads over and beyond the range.
        for (int n = 0; n < 80; n++) begin
            logic [31:0] addr;
            logic [31:0] data;
            int          op;
            op   = $urandom_range(0, 3);
            addr = ($urandom_range(0, 7) == 0) ? 32'($urandom) : 32'($urandom_range(0, 1023));
            data = 32'($urandom);
            case (op)
                0, 1: do_write(addr, data, "rand_write");
                2:    idle_edge(addr, data);
                default: expect_rd(addr, "rand_read");
            endcase
        end
        for (int n = 0; n < 24; n++) begin
            expect_rd(32'($urandom_range(0, 1023)), "rand_sweep");
        end

        // Reset between edges, with a write attempted while it is held.
        bus.A  = 32'd1000;
        bus.WD = 32'hFEEDFACE;
        bus.WE = 1'b1;
        rst    = 1'b1;
        model_reset();
        #1;
        checks++;
        if (bus.RD !== 32'h21212121) begin
            failures++;
            $display("FAIL async_reset_immediate: A=%h RD=%h expected=%h", bus.A, bus.RD, 32'h21212121);
        end
        begin
            exp_t e;
            e.addr = 32'd1000;
            e.exp  = 32'h21212121;
            e.name = "reset_held_write";
            sb_q.push_back(e);
        end
        @(posedge clk); #1;
        bus.WE = 1'b0;
        rst    = 1'b0;
        expect_rd(32'd1000, "after_reset_1000");
        expect_rd(32'd1010, "after_reset_1010");
        expect_rd(32'd1020, "after_reset_1020");
        expect_rd(32'd0,    "after_reset_word0");
        expect_rd(32'd1004, "after_reset_1004");

        @(posedge clk); #1;
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: pending=%0d expected=0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
